// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - operand/result and ALU bus bundle for the MULTU/DIVU sequencer
//
// Signals:
//   start, op, opA, opB   request from the control unit
//   busy, done, hi, lo    status and HI/LO results
//   alu_a, alu_b, alu_ctl operands and control driven to the shared ALU
//   alu_res               combinational result returned by the shared ALU
// Modports:
//   master  control unit + ALU side (drives request and alu_res)
//   slave   the sequencer
interface muldiv_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_res;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, opA, opB, alu_res,
        input  alu_a, alu_b, alu_ctl, busy, done, hi, lo
    );

    modport slave (
        input  start, op, opA, opB, alu_res,
        output alu_a, alu_b, alu_ctl, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULTU/DIVU sequencer sharing the core ALU
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   m      muldiv_seq_if.slave: start/op/opA/opB in, busy/done/hi/lo out,
//          alu_a/alu_b/alu_ctl out to the shared ALU, alu_res back
// Build option:
//   MULDIV_SIGNED_EN  enables signed MULT/DIV (op[1]=1) via an extra FIX state;
//                     when undefined op[1] is ignored.
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   m
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef MULDIV_SIGNED_EN
    localparam logic [1:0] S_FIX  = 2'd3;
`endif

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam int         CW      = $clog2(ITER);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;
    logic [31:0]   mcand;
    logic [31:0]   divisor;
    logic          is_div;
    logic          done_r;

    // Operand magnitudes as latched in IDLE.
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;

`ifdef MULDIV_SIGNED_EN
    logic          is_signed;
    logic          neg_lo;
    logic          neg_hi;
    logic          sign_a;
    logic          sign_b;
    logic          hi_inc;

    assign sign_a = m.op[1] & m.opA[31];
    assign sign_b = m.op[1] & m.opB[31];
    assign mag_a  = sign_a ? (~m.opA + 32'd1) : m.opA;
    assign mag_b  = sign_b ? (~m.opB + 32'd1) : m.opB;
    // DIV negates hi on its own (plain two's complement); MULT negates the
    // 64-bit pair, so hi only receives the +1 when lo is zero.
    assign hi_inc = is_div | (lo_r == 32'd0);
`else
    logic          unused_op_hi;

    assign unused_op_hi = m.op[1];
    assign mag_a        = m.opA;
    assign mag_b        = m.opB;
`endif

    // Divide iteration: shift one dividend bit into the partial remainder.
    // rmsb is the 33rd bit, which makes the subtraction unconditionally fit.
    logic        rmsb;
    logic [31:0] rs;
    logic        accept;
    logic        carry;

    assign rmsb   = hi_r[31];
    assign rs     = {hi_r[30:0], lo_r[31]};
    assign accept = rmsb | (rs >= divisor);
    assign carry  = (m.alu_res < hi_r);

    always_comb begin
        m.alu_a   = 32'd0;
        m.alu_b   = 32'd0;
        m.alu_ctl = ALU_ADD;
        if (state == S_RUN) begin
            if (is_div) begin
                m.alu_ctl = ALU_SUB;
                m.alu_a   = rs;
                m.alu_b   = divisor;
            end else begin
                m.alu_a   = hi_r;
                m.alu_b   = mcand;
            end
        end
`ifdef MULDIV_SIGNED_EN
        else if (state == S_FIX) begin
            m.alu_ctl = ALU_SUB;
            m.alu_b   = lo_r;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            mcand   <= 32'd0;
            divisor <= 32'd0;
            is_div  <= 1'b0;
            done_r  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            is_signed <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (m.start) begin
                        count   <= '0;
                        is_div  <= m.op[0];
                        mcand   <= mag_a;
                        divisor <= mag_b;
`ifdef MULDIV_SIGNED_EN
                        is_signed <= m.op[1];
                        neg_lo    <= sign_a ^ sign_b;
                        neg_hi    <= m.op[0] ? sign_a : (sign_a ^ sign_b);
`endif
                        if (m.op[0] && (m.opB == 32'd0)) begin
                            hi_r  <= m.opA;
                            lo_r  <= 32'hFFFF_FFFF;
                            state <= S_DONE;
                        end else begin
                            hi_r  <= 32'd0;
                            lo_r  <= m.op[0] ? mag_a : mag_b;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        hi_r <= accept ? m.alu_res : rs;
                        lo_r <= {lo_r[30:0], accept};
                    end else if (lo_r[0]) begin
                        hi_r <= {carry, m.alu_res[31:1]};
                        lo_r <= {m.alu_res[0], lo_r[31:1]};
                    end else begin
                        hi_r <= {1'b0, hi_r[31:1]};
                        lo_r <= {hi_r[0], lo_r[31:1]};
                    end
                    if (count == CW'(ITER - 1)) begin
`ifdef MULDIV_SIGNED_EN
                        state <= is_signed ? S_FIX : S_DONE;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef MULDIV_SIGNED_EN
                S_FIX: begin
                    if (neg_lo) lo_r <= m.alu_res;
                    if (neg_hi) hi_r <= ~hi_r + {31'd0, hi_inc};
                    state <= S_DONE;
                end
`endif
                S_DONE: begin
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MULDIV_SIGNED_EN
    assign m.busy = (state == S_RUN) || (state == S_FIX);
`else
    assign m.busy = (state == S_RUN);
`endif
    assign m.done = done_r;
    assign m.hi   = hi_r;
    assign m.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard testbench for muldiv_seq
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .m     (bus)
    );

    // Reference ALU: add for 0010, subtract for 0110.
    assign bus.alu_res = (bus.alu_ctl == 4'b0110) ? (bus.alu_a - bus.alu_b)
                                                  : (bus.alu_a + bus.alu_b);

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          mark;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   neg_cnt = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every done pulse; any done
    // while nothing is outstanding is an error.
    always @(negedge clk) begin
        neg_cnt++;
        if (mon_en && bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(bus.done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_hi"},  64'(bus.hi), 64'(mon_e.hi));
                chk({mon_e.tag, "_lo"},  64'(bus.lo), 64'(mon_e.lo));
                chk({mon_e.tag, "_lat"}, 64'(neg_cnt - mon_e.mark), 64'(mon_e.lat));
            end
        end
    end

    task automatic start_op(input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        exp_t        e;
        logic [63:0] p;
        int          sa;
        int          sbv;
        sa  = a;
        sbv = b;
        e.tag = tag;
        lat = 34;
        if (op[0] && b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            lat  = 2;
        end
`ifdef MULDIV_SIGNED_EN
        else if (op[1] && op[0]) begin
            e.lo = 32'(sa / sbv);
            e.hi = 32'(sa % sbv);
            lat  = 35;
        end else if (op[1]) begin
            p    = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            e.hi = p[63:32];
            e.lo = p[31:0];
            lat  = 35;
        end
`endif
        else if (op[0]) begin
            e.lo = a / b;
            e.hi = a % b;
        end else begin
            p    = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end
        e.lat = lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        @(posedge clk);
        e.mark = neg_cnt;
        sb.push_back(e);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int lat;
        start_op(tag, op, a, b, lat);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(bus.busy), (lat > 2) ? 64'd1 : 64'd0);
        if (lat > 2)
            chk({tag, "_ctl"}, 64'(bus.alu_ctl), op[0] ? 64'h6 : 64'h2);
        wait_done();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int       lat;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.opA   = 32'd0;
        bus.opB   = 32'd0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_hi",   64'(bus.hi), 64'd0);
        chk("rst_lo",   64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_ctl",  64'(bus.alu_ctl), 64'h2);
        chk("rst_alua", 64'(bus.alu_a), 64'd0);
        mon_en = 1'b1;

        run_op("mul_ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_100_7", 2'b01, 32'd100, 32'd7);
        run_op("div_msb",  2'b01, 32'h8000_0000, 32'd3);
        run_op("div_zero", 2'b01, 32'd5, 32'd0);
        run_op("mul_zero", 2'b00, 32'h1234_5678, 32'd0);
        run_op("div_one",  2'b01, 32'hDEAD_BEEF, 32'd1);
        run_op("div_big",  2'b01, 32'd3, 32'hFFFF_FFFF);

        for (int i = 0; i < 4; i++) begin
            run_op("mul_rnd", 2'b00, $urandom, $urandom);
            run_op("div_rnd", 2'b01, $urandom, $urandom_range(32'hFFFF, 1));
        end

        // Second start while busy must not disturb the running operation.
        start_op("ignore", 2'b00, 32'd123456, 32'd789, lat);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.opA   = 32'd99;
        bus.opB   = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (40) @(posedge clk);

        // Reset at iteration 10 aborts with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opA   = 32'hFFFF_0000;
        bus.opB   = 32'h0000_FFFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_pre", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_hi",   64'(bus.hi), 64'd0);
        chk("abort_lo",   64'(bus.lo), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        repeat (40) @(posedge clk);
        run_op("after_abort", 2'b01, 32'd1000, 32'd33);

`ifdef MULDIV_SIGNED_EN
        run_op("smul",  2'b10, 32'hFFFF_FFFD, 32'd5);
        run_op("sdiv",  2'b11, 32'hFFFF_FFF9, 32'd2);
        run_op("sdiv2", 2'b11, 32'd100, 32'hFFFF_FFF9);
        run_op("sdivz", 2'b11, 32'hFFFF_FFF9, 32'd0);
`else
        // op[1] is ignored: signed encodings run as their unsigned variants.
        run_op("op10_mul", 2'b10, 32'hFFFF_FFFD, 32'd5);
        run_op("op11_div", 2'b11, 32'hFFFF_FFF9, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
